// File: rtl/qkv_mem_port_sched.sv
// Phase scheduler and port arbiter for one single-port Q/K/V projection SRAM.
// Three requesters share the SRAM: projection writer (P), attention reader (A)
// and host (H). Only one requester is legal per phase, so arbitration reduces
// to a phase-qualified grant. Read returns are tagged with their requester
// through a READ_LAT-deep tag pipeline that tracks the SRAM read latency.
module qkv_mem_port_sched #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 128,
  parameter int READ_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              proj_done_i,
  input  logic              attn_done_i,
  input  logic              p_req_i,
  input  logic [ADDR_W-1:0] p_addr_i,
  input  logic [DATA_W-1:0] p_wdata_i,
  output logic              p_gnt_o,
  input  logic              a_req_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  output logic              a_gnt_o,
  input  logic              h_req_i,
  input  logic              h_we_i,
  input  logic [ADDR_W-1:0] h_addr_i,
  input  logic [DATA_W-1:0] h_wdata_i,
  output logic              h_gnt_o,
  output logic              mem_web_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i,
  output logic              rd_valid_o,
  output logic [1:0]        rd_tag_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [1:0]        phase_o,
  output logic              attn_start_o,
  output logic [2:0]        err_o,
  output logic [15:0]       wr_cnt_o,
  output logic [15:0]       rd_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROJ = 2'd1,
    ST_ATTN = 2'd2,
    ST_DONE = 2'd3
  } phase_e;

  localparam logic [1:0] TAG_NONE = 2'b00;
  localparam logic [1:0] TAG_A    = 2'b01;
  localparam logic [1:0] TAG_H    = 2'b10;

  phase_e      phase_q, phase_d;
  logic        pend_q, pend_d;          // attn_done seen while A reads still in flight
  logic        attn_start_q, attn_start_d;
  logic [2:0]  err_q, err_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]  tag_q [READ_LAT];
  logic [1:0]  tag_in;

  logic        host_ok;
  logic [2:0]  illegal;
  logic        a_busy;

  // Phase-qualified grants and illegal-request detection
  always_comb begin
    host_ok = (phase_q == ST_IDLE) || (phase_q == ST_DONE);
    p_gnt_o = p_req_i && (phase_q == ST_PROJ);
    a_gnt_o = a_req_i && (phase_q == ST_ATTN);
    h_gnt_o = h_req_i && host_ok;
    illegal = {h_req_i && !host_ok,
               a_req_i && (phase_q != ST_ATTN),
               p_req_i && (phase_q != ST_PROJ)};
  end

  // SRAM port mux; with no grant the port performs a harmless read of word 0
  always_comb begin
    mem_web_o  = 1'b1;
    mem_addr_o = '0;
    mem_din_o  = '0;
    if (p_gnt_o) begin
      mem_web_o  = 1'b0;
      mem_addr_o = p_addr_i;
      mem_din_o  = p_wdata_i;
    end else if (a_gnt_o) begin
      mem_addr_o = a_addr_i;
    end else if (h_gnt_o) begin
      mem_web_o  = ~h_we_i;
      mem_addr_o = h_addr_i;
      mem_din_o  = h_wdata_i;
    end
  end

  // Tag entering the return pipeline for this cycle's access
  always_comb begin
    tag_in = TAG_NONE;
    if (a_gnt_o)                 tag_in = TAG_A;
    else if (h_gnt_o && !h_we_i) tag_in = TAG_H;
  end

  // A read counts as in flight until the cycle its data returns; the stage
  // holding a returning read is excluded so DONE follows the last rd_valid.
  always_comb begin
    a_busy = a_gnt_o;
    for (int i = 0; i < READ_LAT - 1; i++) begin
      if (tag_q[i] == TAG_A) a_busy = 1'b1;
    end
  end

  // Tag pipeline first stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tag_q[0] <= TAG_NONE;
    else         tag_q[0] <= tag_in;
  end

  generate
    for (genvar gi = 1; gi < READ_LAT; gi++) begin : g_tag_stage
      // Tag pipeline stage gi shifts from stage gi-1
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tag_q[gi] <= TAG_NONE;
        else         tag_q[gi] <= tag_q[gi-1];
      end
    end
  endgenerate

  // Next-state logic: phase sequencing, error flags and run counters
  always_comb begin
    phase_d      = phase_q;
    pend_d       = pend_q;
    attn_start_d = 1'b0;
    err_d        = err_q | illegal;
    wr_cnt_d     = (p_gnt_o && (wr_cnt_q != 16'hFFFF)) ? wr_cnt_q + 16'd1 : wr_cnt_q;
    rd_cnt_d     = (a_gnt_o && (rd_cnt_q != 16'hFFFF)) ? rd_cnt_q + 16'd1 : rd_cnt_q;
    case (phase_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          phase_d  = ST_PROJ;
          err_d    = illegal;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
          pend_d   = 1'b0;
        end
      end
      ST_PROJ: begin
        if (proj_done_i) begin
          phase_d      = ST_ATTN;
          attn_start_d = 1'b1;
        end
      end
      ST_ATTN: begin
        if ((pend_q || attn_done_i) && !a_busy) begin
          phase_d = ST_DONE;
          pend_d  = 1'b0;
        end else if (attn_done_i) begin
          pend_d = 1'b1;
        end
      end
      default: phase_d = ST_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q      <= ST_IDLE;
      pend_q       <= 1'b0;
      attn_start_q <= 1'b0;
      err_q        <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
    end else begin
      phase_q      <= phase_d;
      pend_q       <= pend_d;
      attn_start_q <= attn_start_d;
      err_q        <= err_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
    end
  end

  assign rd_valid_o   = (tag_q[READ_LAT-1] != TAG_NONE);
  assign rd_tag_o     = tag_q[READ_LAT-1];
  assign rd_data_o    = mem_dout_i;
  assign phase_o      = phase_q;
  assign attn_start_o = attn_start_q;
  assign err_o        = err_q;
  assign wr_cnt_o     = wr_cnt_q;
  assign rd_cnt_o     = rd_cnt_q;

endmodule

// File: tb/tb_qkv_mem_port_sched.sv
// Bench for qkv_mem_port_sched: directed run-through followed by randomized
// traffic, every cycle compared against a transaction-level reference model.
module tb_qkv_mem_port_sched;
  localparam int AW  = 7;
  localparam int DW  = 128;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, proj_done, attn_done;
  logic          p_req, a_req, h_req, h_we;
  logic [AW-1:0] p_addr, a_addr, h_addr;
  logic [DW-1:0] p_wdata, h_wdata;
  logic          p_gnt, a_gnt, h_gnt, mem_web, rd_valid, attn_start;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout, rd_data;
  logic [1:0]    rd_tag, phase;
  logic [2:0]    err;
  logic [15:0]   wr_cnt, rd_cnt;

  qkv_mem_port_sched #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .proj_done_i(proj_done),
    .attn_done_i(attn_done),
    .p_req_i(p_req), .p_addr_i(p_addr), .p_wdata_i(p_wdata), .p_gnt_o(p_gnt),
    .a_req_i(a_req), .a_addr_i(a_addr), .a_gnt_o(a_gnt),
    .h_req_i(h_req), .h_we_i(h_we), .h_addr_i(h_addr), .h_wdata_i(h_wdata),
    .h_gnt_o(h_gnt),
    .mem_web_o(mem_web), .mem_addr_o(mem_addr), .mem_din_o(mem_din),
    .mem_dout_i(mem_dout),
    .rd_valid_o(rd_valid), .rd_tag_o(rd_tag), .rd_data_o(rd_data),
    .phase_o(phase), .attn_start_o(attn_start), .err_o(err),
    .wr_cnt_o(wr_cnt), .rd_cnt_o(rd_cnt)
  );

  // Behavioural SRAM with LAT-cycle registered read
  logic [DW-1:0] sram [128];
  logic [DW-1:0] sram_pipe [LAT];
  always @(posedge clk) begin
    if (!mem_web) sram[mem_addr] <= mem_din;
    sram_pipe[0] <= sram[mem_addr];
    for (int i = 1; i < LAT; i++) sram_pipe[i] <= sram_pipe[i-1];
  end
  assign mem_dout = sram_pipe[LAT-1];

  // Reference model state
  typedef struct {
    int            cyc;
    logic [1:0]    tag;
    logic [DW-1:0] data;
  } ret_t;

  int            m_phase;
  bit            m_pend;
  logic [2:0]    m_err;
  int            m_wr, m_rd;
  bit            m_as;
  logic [DW-1:0] exp_mem [128];
  ret_t          rq [$];
  int            cyc;
  int            n_chk, n_pass;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
  endtask

  // Compare DUT against the model mid-cycle, then advance the model
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_phase = 0; m_pend = 0; m_err = 0; m_wr = 0; m_rd = 0; m_as = 0;
      rq.delete();
      chk("rst_phase", phase, 0);
      chk("rst_attn_start", attn_start, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_tag", rd_tag, 0);
      chk("rst_err", err, 0);
      chk("rst_wr_cnt", wr_cnt, 0);
      chk("rst_rd_cnt", rd_cnt, 0);
    end else begin
      bit            lp, la, lh, gp, ga, gh, ev, a_left, st_ok;
      logic          e_web;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_din, e_data;
      logic [1:0]    e_tag;
      logic [2:0]    ill;
      lp = (m_phase == 1);
      la = (m_phase == 2);
      lh = (m_phase == 0) || (m_phase == 3);
      gp = p_req && lp;
      ga = a_req && la;
      gh = h_req && lh;
      e_web = 1'b1; e_addr = '0; e_din = '0;
      if (gp)      begin e_web = 1'b0;   e_addr = p_addr; e_din = p_wdata; end
      else if (ga) begin                 e_addr = a_addr;                  end
      else if (gh) begin e_web = ~h_we;  e_addr = h_addr; e_din = h_wdata; end
      ev = 0; e_tag = 2'b00; e_data = '0;
      foreach (rq[i]) if (rq[i].cyc == cyc) begin
        ev = 1; e_tag = rq[i].tag; e_data = rq[i].data;
      end
      chk("p_gnt", p_gnt, gp);
      chk("a_gnt", a_gnt, ga);
      chk("h_gnt", h_gnt, gh);
      chk("mem_web", mem_web, e_web);
      chk("mem_addr", mem_addr, e_addr);
      if (!ga) chk("mem_din", mem_din, e_din);
      chk("rd_valid", rd_valid, ev);
      chk("rd_tag", rd_tag, e_tag);
      if (ev) chk("rd_data", rd_data, e_data);
      chk("phase", phase, m_phase);
      chk("attn_start", attn_start, m_as);
      chk("err", err, m_err);
      chk("wr_cnt", wr_cnt, m_wr);
      chk("rd_cnt", rd_cnt, m_rd);
      if (ev) $display("cyc=%0d return tag=%0b data=%0h phase=%0d", cyc, rd_tag, rd_data, phase);

      // Advance the model by one cycle
      rq = rq.find(x) with (x.cyc > cyc);
      if (ga) rq.push_back('{cyc + LAT, 2'b01, exp_mem[a_addr]});
      if (gh && !h_we) rq.push_back('{cyc + LAT, 2'b10, exp_mem[h_addr]});
      if (gp) exp_mem[p_addr] = p_wdata;
      if (gh && h_we) exp_mem[h_addr] = h_wdata;
      if (gp && m_wr < 65535) m_wr++;
      if (ga && m_rd < 65535) m_rd++;
      ill = {h_req && !lh, a_req && !la, p_req && !lp};
      st_ok = lh && start;
      m_err = st_ok ? ill : (m_err | ill);
      m_as = lp && proj_done;
      if (st_ok) begin
        m_phase = 1; m_wr = 0; m_rd = 0; m_pend = 0;
      end else if (lp && proj_done) begin
        m_phase = 2;
      end else if (la) begin
        a_left = 0;
        foreach (rq[i]) if (rq[i].tag == 2'b01 && rq[i].cyc > cyc) a_left = 1;
        if (attn_done) m_pend = 1;
        if (m_pend && !a_left) begin m_phase = 3; m_pend = 0; end
      end
    end
  end

  task automatic cyc_go();
    @(posedge clk); #1;
    start = 0; proj_done = 0; attn_done = 0;
    p_req = 0; a_req = 0; h_req = 0; h_we = 0;
    p_addr = '0; a_addr = '0; h_addr = '0; p_wdata = '0; h_wdata = '0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    for (int i = 0; i < 128; i++) exp_mem[i] = '0;
    rst_n = 0;
    start = 0; proj_done = 0; attn_done = 0;
    p_req = 0; a_req = 0; h_req = 0; h_we = 0;
    p_addr = '0; a_addr = '0; h_addr = '0; p_wdata = '0; h_wdata = '0;
    repeat (3) cyc_go();
    rst_n = 1;
    cyc_go();

    // Projection run: fill the whole memory with data = address
    start = 1; cyc_go();
    for (int i = 0; i < 128; i++) begin
      p_req = 1; p_addr = AW'(i); p_wdata = DW'(i); cyc_go();
    end
    proj_done = 1; cyc_go();
    cyc_go();

    // Back-to-back A reads, attn_done together with the last one
    for (int i = 5; i <= 7; i++) begin
      a_req = 1; a_addr = AW'(i);
      if (i == 7) attn_done = 1;
      cyc_go();
    end
    repeat (5) cyc_go();

    // Host access in DONE
    h_req = 1; h_addr = 7'd127; cyc_go();
    repeat (3) cyc_go();
    h_req = 1; h_we = 1; h_addr = 7'd3; h_wdata = 128'hAB; cyc_go();
    h_req = 1; h_addr = 7'd3; cyc_go();
    repeat (3) cyc_go();

    // Illegal requests: host in PROJ, projection writer in ATTN
    start = 1; cyc_go();
    h_req = 1; h_addr = 7'd9; proj_done = 1; cyc_go();
    p_req = 1; p_addr = 7'd4; p_wdata = 128'h55; cyc_go();
    attn_done = 1; cyc_go();
    repeat (2) cyc_go();
    start = 1; cyc_go();
    repeat (2) cyc_go();

    // Reset with two A reads in flight
    proj_done = 1; cyc_go();
    a_req = 1; a_addr = 7'd10; cyc_go();
    a_req = 1; a_addr = 7'd11; cyc_go();
    rst_n = 0; cyc_go(); cyc_go();
    rst_n = 1; repeat (4) cyc_go();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 0; cyc_go(); cyc_go(); rst_n = 1;
      end
      start     = ($urandom_range(0, 99) < 4);
      proj_done = ($urandom_range(0, 99) < 4);
      attn_done = ($urandom_range(0, 99) < 5);
      p_req = $urandom_range(0, 1); p_addr = AW'($urandom_range(0, 15));
      p_wdata = {$urandom, $urandom, $urandom, $urandom};
      a_req = $urandom_range(0, 1); a_addr = AW'($urandom_range(0, 15));
      h_req = $urandom_range(0, 1); h_we = $urandom_range(0, 1);
      h_addr = AW'($urandom_range(0, 15));
      h_wdata = {$urandom, $urandom, $urandom, $urandom};
      cyc_go();
    end
    repeat (4) cyc_go();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
